// File: rtl/vector_cmd_parser.sv
// vector_cmd_parser: assembles 4-byte UART vector packets into {cmd,x,y} entries,
// queues them in a FIFO and issues one jump/draw pulse per entry while the line
// drawer reports ready. Flags framing errors (sync_err) and dropped packets (overflow).
//
// Build option: define PARSER_TIMEOUT_EN to abort a partial packet after
// TIMEOUT_CYCLES idle clocks; left undefined, a partial packet waits indefinitely.
module vector_cmd_parser #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_dv,
    input  logic [7:0]                    rx_byte,
    input  logic                          ready,
    output logic [11:0]                   x,
    output logic [11:0]                   y,
    output logic                          draw,
    output logic                          jump,
    output logic                          sync_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StB0, StB1, StB2, StB3} state_e;

    // Parser state and partially assembled packet
    state_e      state_q;
    logic [1:0]  cmd_q;
    logic [11:0] pkt_x_q;
    logic [6:0]  pkt_yh_q;
    logic        sync_err_q;
    logic        timeout_hit;

    // FIFO: entry = {is_draw, x[11:0], y[11:0]}
    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Issue side
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic        draw_q;
    logic        jump_q;
    logic        gap_q;
    logic        overflow_q;

    logic        pkt_done;
    logic        push_req;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic [24:0] pkt_entry;
    logic [24:0] head;

`ifdef PARSER_TIMEOUT_EN
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;

    // Idle timer for a partial packet; saturates so a stall aborts only once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (rx_dv) begin
            timer_q <= '0;
        end else if (state_q != StB0 && timer_q != TimerMax) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign timeout_hit = !rx_dv && (state_q != StB0) && (timer_q == TimerMax);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Packet parser FSM: advances on rx_dv, resynchronises on any sync-marked byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StB0;
            cmd_q      <= '0;
            pkt_x_q    <= '0;
            pkt_yh_q   <= '0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            if (rx_dv) begin
                if (rx_byte[7]) begin
                    // A marker outside B0 means the previous packet was cut short
                    sync_err_q     <= (state_q != StB0);
                    cmd_q          <= rx_byte[6:5];
                    pkt_x_q[11:7]  <= rx_byte[4:0];
                    state_q        <= StB1;
                end else begin
                    unique case (state_q)
                        StB0: sync_err_q <= 1'b1;
                        StB1: begin
                            pkt_x_q[6:0] <= rx_byte[6:0];
                            state_q      <= StB2;
                        end
                        StB2: begin
                            pkt_yh_q <= rx_byte[6:0];
                            state_q  <= StB3;
                        end
                        StB3: state_q <= StB0;
                    endcase
                end
            end else if (timeout_hit) begin
                sync_err_q <= 1'b1;
                state_q    <= StB0;
            end
        end
    end

    // Push/pop decisions; a full FIFO still accepts when the head leaves on the same edge
    always_comb begin
        pkt_done  = rx_dv && !rx_byte[7] && (state_q == StB3);
        push_req  = pkt_done && !cmd_q[1];
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        pop       = (count_q != '0) && ready && !gap_q;
        push      = push_req && (!fifo_full || pop);
        pkt_entry = {cmd_q[0], pkt_x_q, pkt_yh_q, rx_byte[6:2]};
        head      = mem_q[rd_ptr_q];
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue stage: one pulse per pop, then a dead cycle while the drawer drops ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q        <= '0;
            y_q        <= '0;
            draw_q     <= 1'b0;
            jump_q     <= 1'b0;
            gap_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            draw_q     <= 1'b0;
            jump_q     <= 1'b0;
            gap_q      <= pop;
            overflow_q <= push_req && fifo_full && !pop;
            if (pop) begin
                x_q    <= head[23:12];
                y_q    <= head[11:0];
                draw_q <= head[24];
                jump_q <= !head[24];
            end
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign draw       = draw_q;
    assign jump       = jump_q;
    assign sync_err   = sync_err_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_vector_cmd_parser.sv
// Self-checking bench for vector_cmd_parser: expected issues are queued when a
// packet is sent and compared when the DUT pulses draw/jump.
module tb_vector_cmd_parser;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        ready = 1'b0;
    logic [11:0] x;
    logic [11:0] y;
    logic        draw;
    logic        jump;
    logic        sync_err;
    logic        overflow;
    logic [4:0]  fifo_count;

    vector_cmd_parser #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .ready      (ready),
        .x          (x),
        .y          (y),
        .draw       (draw),
        .jump       (jump),
        .sync_err   (sync_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;
    int n_sync   = 0;
    int n_ovf    = 0;
    int exp_ovf  = 0;
    logic        prev_pulse = 1'b0;
    logic [24:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [1:0] cmd, input logic [11:0] px,
                                           input logic [11:0] py);
        return {1'b1, cmd, px[11:7], 1'b0, px[6:0], 1'b0, py[11:5], 1'b0, py[4:0], 2'b00};
    endfunction

    // Monitor: counts flag pulses and checks every issue against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            prev_pulse = 1'b0;
        end else begin
            if (sync_err) n_sync++;
            if (overflow) n_ovf++;
            if (draw || jump) begin
                n_issue++;
                check_eq("pulse_spacing", {31'd0, prev_pulse}, 32'd0);
                check_eq("draw_jump_exclusive", {31'd0, draw && jump}, 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_issue", {30'd0, draw, jump}, 32'd0);
                end else begin
                    logic [24:0] e;
                    e = sb.pop_front();
                    check_eq("issue_kind", {31'd0, draw}, {31'd0, e[24]});
                    check_eq("issue_x", {20'd0, x}, {20'd0, e[23:12]});
                    check_eq("issue_y", {20'd0, y}, {20'd0, e[11:0]});
                end
            end
            prev_pulse = draw || jump;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [1:0] cmd, input logic [11:0] px, input logic [11:0] py);
        logic [31:0] w;
        w = encode(cmd, px, py);
        if (!cmd[1]) begin
            if (sb.size() >= DEPTH) exp_ovf++;
            else sb.push_back({cmd[0], px, py});
        end
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Hard stop in case a wait escapes its bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0;
        int i0;
        logic [31:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_xy", {8'd0, x, y}, 32'd0);
        check_eq("rst_pulses", {28'd0, draw, jump, sync_err, overflow}, 32'd0);
        check_eq("rst_count", {27'd0, fifo_count}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: jump with exact 2-cycle latency
        ready = 1'b1;
        w = encode(2'b00, 12'hFFF, 12'h320);
        sb.push_back({1'b0, 12'hFFF, 12'h320});
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = w[7:0];
        @(negedge clk);
        rx_dv = 1'b0;
        check_eq("t1_not_early", {31'd0, jump}, 32'd0);
        @(negedge clk);
        check_eq("t1_jump", {31'd0, jump}, 32'd1);
        check_eq("t1_x", {20'd0, x}, 32'hFFF);
        check_eq("t1_y", {20'd0, y}, 32'h320);
        @(negedge clk);
        check_eq("t1_one_cycle", {31'd0, jump}, 32'd0);
        check_eq("t1_xy_hold", {8'd0, x, y}, {8'd0, 12'hFFF, 12'h320});
        wait_drain(50);

        // 2: queue while not ready, then drain in order
        ready = 1'b0;
        i0 = n_issue;
        send_pkt(2'b01, 12'h123, 12'h456);
        send_pkt(2'b01, 12'h800, 12'h001);
        send_pkt(2'b01, 12'h07E, 12'hABC);
        repeat (4) @(negedge clk);
        check_eq("t2_count", {27'd0, fifo_count}, 32'd3);
        check_eq("t2_no_issue", n_issue - i0, 32'd0);
        ready = 1'b1;
        wait_drain(50);
        check_eq("t2_issued", n_issue - i0, 32'd3);
        check_eq("t2_empty", {27'd0, fifo_count}, 32'd0);

        // 3: stray byte in B0
        s0 = n_sync;
        send_byte(8'h05);
        check_eq("t3_sync", n_sync - s0, 32'd1);
        sb.push_back({1'b1, 12'h000, 12'h000});
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_drain(50);
        check_eq("t3_sync_once", n_sync - s0, 32'd1);

        // 4: marker mid-packet restarts parsing
        s0 = n_sync;
        send_byte(8'h80);
        send_byte(8'h11);
        sb.push_back({1'b1, 12'h07F, 12'hFFF});
        send_byte(8'hA0);
        check_eq("t4_sync", n_sync - s0, 32'd1);
        send_byte(8'h7F);
        send_byte(8'h7F);
        send_byte(8'h7C);
        wait_drain(50);
        check_eq("t4_sync_once", n_sync - s0, 32'd1);

        // Reserved command: parsed, no push, no flag
        i0 = n_issue;
        s0 = n_ovf;
        send_pkt(2'b10, 12'h555, 12'h555);
        send_pkt(2'b11, 12'hAAA, 12'hAAA);
        repeat (6) @(negedge clk);
        check_eq("rsv_no_issue", n_issue - i0, 32'd0);
        check_eq("rsv_count", {27'd0, fifo_count}, 32'd0);
        check_eq("rsv_no_ovf", n_ovf - s0, 32'd0);

        // 5: overflow on DEPTH+1 packets
        ready = 1'b0;
        s0 = n_ovf;
        exp_ovf = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_pkt(i[0] ? 2'b01 : 2'b00, 12'(i * 37), 12'(4095 - i * 11));
        end
        repeat (2) @(negedge clk);
        check_eq("t5_full", {27'd0, fifo_count}, DEPTH);
        check_eq("t5_ovf", n_ovf - s0, exp_ovf);
        check_eq("t5_ovf_one", n_ovf - s0, 32'd1);
        ready = 1'b1;
        wait_drain(200);
        check_eq("t5_empty", {27'd0, fifo_count}, 32'd0);

        // Reset mid-packet with queued entries
        ready = 1'b0;
        send_pkt(2'b01, 12'h111, 12'h222);
        send_pkt(2'b00, 12'h333, 12'h444);
        send_byte(8'h80);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("rst_mid_count", {27'd0, fifo_count}, 32'd0);
        check_eq("rst_mid_pulses", {28'd0, draw, jump, sync_err, overflow}, 32'd0);
        reset = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        s0 = n_sync;
        i0 = n_issue;
        send_byte(8'h11);
        check_eq("rst_mid_partial_lost", n_sync - s0, 32'd1);
        repeat (6) @(negedge clk);
        check_eq("rst_mid_no_issue", n_issue - i0, 32'd0);
        send_pkt(2'b01, 12'hFED, 12'h0BA);
        wait_drain(50);

`ifdef PARSER_TIMEOUT_EN
        // 6: idle timeout on a partial packet
        s0 = n_sync;
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = 8'h80;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (45) @(negedge clk);
        check_eq("t6_not_early", n_sync - s0, 32'd0);
        repeat (10) @(negedge clk);
        check_eq("t6_timeout", n_sync - s0, 32'd1);
        repeat (60) @(negedge clk);
        check_eq("t6_once", n_sync - s0, 32'd1);
        send_pkt(2'b00, 12'h246, 12'h8AC);
        wait_drain(50);
        check_eq("t6_no_extra_sync", n_sync - s0, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
